// File: rtl/seq_det_if.sv
// Bus bundle for seq_detector_param: pattern programming, serial input and detection outputs.
// pat_mask exists only when SEQ_DET_MASK_EN is defined.
interface seq_det_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             pat_load;
    logic [PAT_W-1:0] pat_val;
    logic [LEN_W-1:0] pat_len;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] pat_mask;
`endif
    logic             overlap;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
`ifdef SEQ_DET_MASK_EN
        output pat_mask,
`endif
        output pat_load, pat_val, pat_len, overlap, in_valid, in_bit,
        input  match, match_cnt, armed
    );

    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  pat_mask,
`endif
        input  pat_load, pat_val, pat_len, overlap, in_valid, in_bit,
        output match, match_cnt, armed
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (length 1..PAT_W) with Moore match output,
// overlap control and saturating match counter. Define SEQ_DET_MASK_EN for per-bit don't-care masking.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    seq_det_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t           state_r, state_nx;
    logic [PAT_W-1:0] pat_r, pat_nx;
    logic [PAT_W-1:0] hist_r, hist_nx;
    logic [LEN_W-1:0] len_r, len_nx;
    logic [LEN_W-1:0] fill_r, fill_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] cmp_mask;
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic             len_ok;
    logic             hit;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_r, mask_nx;
`endif

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Fill only needs to reach PAT_W; beyond that every length is satisfied.
    function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] v);
        return (v >= LEN_W'(PAT_W)) ? v : v + LEN_W'(1);
    endfunction

    assign len_ok     = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(PAT_W));
    assign hist_shift = {hist_r[PAT_W-2:0], bus.in_bit};
    assign fill_inc   = sat_fill(fill_r);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_r));
        end
    end

`ifdef SEQ_DET_MASK_EN
    assign cmp_mask = len_mask & mask_r;
`else
    assign cmp_mask = len_mask;
`endif

    assign hit = (fill_inc >= len_r) && (((hist_shift ^ pat_r) & cmp_mask) == '0);

    always_comb begin
        state_nx = state_r;
        pat_nx   = pat_r;
        len_nx   = len_r;
        hist_nx  = hist_r;
        fill_nx  = fill_r;
        cnt_nx   = cnt_r;
`ifdef SEQ_DET_MASK_EN
        mask_nx  = mask_r;
`endif
        if (bus.pat_load) begin
            // A load always wins over a coincident input bit.
            pat_nx   = bus.pat_val;
            len_nx   = bus.pat_len;
            hist_nx  = '0;
            fill_nx  = '0;
            cnt_nx   = '0;
`ifdef SEQ_DET_MASK_EN
            mask_nx  = bus.pat_mask;
`endif
            state_nx = len_ok ? ARMED : IDLE;
        end else begin
            case (state_r)
                IDLE: state_nx = IDLE;
                ARMED, MATCH: begin
                    state_nx = ARMED;
                    if (bus.in_valid) begin
                        hist_nx = hist_shift;
                        fill_nx = fill_inc;
                        if (hit) begin
                            state_nx = MATCH;
                            cnt_nx   = sat_cnt(cnt_r);
                            if (!bus.overlap) begin
                                hist_nx = '0;
                                fill_nx = '0;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            pat_r   <= '0;
            len_r   <= '0;
            hist_r  <= '0;
            fill_r  <= '0;
            cnt_r   <= '0;
`ifdef SEQ_DET_MASK_EN
            mask_r  <= '0;
`endif
        end else begin
            state_r <= state_nx;
            pat_r   <= pat_nx;
            len_r   <= len_nx;
            hist_r  <= hist_nx;
            fill_r  <= fill_nx;
            cnt_r   <= cnt_nx;
`ifdef SEQ_DET_MASK_EN
            mask_r  <= mask_nx;
`endif
        end
    end

    assign bus.match     = (state_r == MATCH);
    assign bus.match_cnt = cnt_r;
    assign bus.armed     = (state_r != IDLE);
endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised scoreboard bench for seq_detector_param: two instances (8-bit and 2-bit counters)
// driven identically and compared against a bit-list reference model.
module tb_seq_detector_param;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 8;
    localparam int CNT_S = 2;

    typedef struct {
        bit m;
        int c;
        int cs;
        bit a;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus   ();
    seq_det_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_S)) bus_s ();

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_S)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference model: the list of bits consumed since the last load or flush.
    bit         hbits[$];
    logic [7:0] m_pat;
    logic [7:0] m_mask;
    int         m_len;
    bit         m_armed;
    int         m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic set_inputs(input bit ld, input logic [7:0] v, input int l, input logic [7:0] mk,
                              input bit ov, input bit iv, input bit b);
        bus.pat_load   = ld;   bus_s.pat_load = ld;
        bus.pat_val    = v;    bus_s.pat_val  = v;
        bus.pat_len    = LEN_W'(l); bus_s.pat_len = LEN_W'(l);
        bus.overlap    = ov;   bus_s.overlap  = ov;
        bus.in_valid   = iv;   bus_s.in_valid = iv;
        bus.in_bit     = b;    bus_s.in_bit   = b;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask   = mk;   bus_s.pat_mask = mk;
`else
        if (mk == 8'h00) bus.in_bit = b;
`endif
    endtask

    task automatic cyc(input bit ld, input logic [7:0] v, input int l, input logic [7:0] mk,
                       input bit ov, input bit iv, input bit b);
        exp_t e;
        bit   hit;
        @(negedge clk);
        set_inputs(ld, v, l, mk, ov, iv, b);
        e.m = 1'b0;
        if (ld) begin
            m_pat = v;
            m_len = l;
`ifdef SEQ_DET_MASK_EN
            m_mask = mk;
`else
            m_mask = 8'hFF;
`endif
            hbits.delete();
            m_cnt   = 0;
            m_armed = (l >= 1) && (l <= PAT_W);
        end else if (m_armed && iv) begin
            hbits.push_back(b);
            if (hbits.size() > PAT_W) void'(hbits.pop_front());
            hit = (hbits.size() >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++) begin
                    if (m_mask[k] && (hbits[hbits.size() - 1 - k] != m_pat[k])) hit = 1'b0;
                end
            end
            if (hit) begin
                e.m = 1'b1;
                m_cnt++;
                if (!ov) hbits.delete();
            end
        end
        e.c  = (m_cnt > 255) ? 255 : m_cnt;
        e.cs = (m_cnt > 3) ? 3 : m_cnt;
        e.a  = m_armed;
        q.push_back(e);
    endtask

    task automatic idle(input bit ov);
        cyc(1'b0, 8'h00, 0, 8'hFF, ov, 1'b0, 1'b0);
    endtask

    task automatic stream(input logic [7:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) cyc(1'b0, 8'h00, 0, 8'hFF, ov, 1'b1, bits[i]);
    endtask

    // Monitor: one expectation per pushed cycle, sampled just after the edge that produces it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("match",     bus.match,       e.m);
                chk("match_s",   bus_s.match,     e.m);
                chk("match_cnt", bus.match_cnt,   e.c);
                chk("cnt_sat",   bus_s.match_cnt, e.cs);
                chk("armed",     bus.armed,       e.a);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_inputs(1'b0, 8'h00, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        m_armed = 1'b0; m_cnt = 0; m_len = 0; m_pat = '0; m_mask = 8'hFF;
        #12;
        chk("rst_match", bus.match, 0);
        chk("rst_cnt",   bus.match_cnt, 0);
        chk("rst_armed", bus.armed, 0);
        @(negedge clk);
        reset = 1'b0;

        // Overlapping 1011: hits after bits 4 and 7.
        cyc(1'b1, 8'b0000_1011, 4, 8'hFF, 1'b1, 1'b0, 1'b0);
        stream(8'b0101_1011, 7, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("ovl_cnt", bus.match_cnt, 2);

        // Non-overlapping: single hit.
        cyc(1'b1, 8'b0000_1011, 4, 8'hFF, 1'b0, 1'b0, 1'b0);
        stream(8'b0101_1011, 7, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("novl_cnt", bus.match_cnt, 1);

        // 111 with gaps between valid bits.
        cyc(1'b1, 8'b0000_0111, 3, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 0, 8'hFF, 1'b1, 1'b1, 1'b1);
            idle(1'b1);
        end
        @(negedge clk);
        chk("gap_cnt", bus.match_cnt, 3);

        // Counter saturation on the narrow instance.
        cyc(1'b1, 8'b0000_0001, 1, 8'hFF, 1'b1, 1'b0, 1'b0);
        stream(8'b0001_1111, 5, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("sat_cnt_s", bus_s.match_cnt, 3);
        chk("sat_cnt",   bus.match_cnt, 5);

        // Invalid lengths, then load/valid collision.
        cyc(1'b1, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0);
        stream(8'b0000_0000, 4, 1'b1);
        cyc(1'b1, 8'hFF, 9, 8'hFF, 1'b1, 1'b0, 1'b0);
        stream(8'b1111_1111, 8, 1'b1);
        cyc(1'b1, 8'b0000_0010, 2, 8'hFF, 1'b1, 1'b1, 1'b1);
        stream(8'b0000_0010, 3, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("collide_armed", bus.armed, 1);
        chk("collide_cnt",   bus.match_cnt, 1);

        // Asynchronous reset mid-pattern.
        cyc(1'b1, 8'b0000_1011, 4, 8'hFF, 1'b1, 1'b0, 1'b0);
        stream(8'b0000_0010, 2, 1'b1);
        @(negedge clk);
        set_inputs(1'b0, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_match", bus.match, 0);
        chk("arst_cnt",   bus.match_cnt, 0);
        chk("arst_armed", bus.armed, 0);
        m_armed = 1'b0; m_cnt = 0; m_len = 0; hbits.delete();
        @(negedge clk);
        reset = 1'b0;
        stream(8'b0000_0011, 2, 1'b1);

`ifdef SEQ_DET_MASK_EN
        cyc(1'b1, 8'b0000_1011, 4, 8'b0000_1101, 1'b0, 1'b0, 1'b0);
        stream(8'b0000_1001, 4, 1'b0);
        stream(8'b0000_1011, 4, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("mask_cnt", bus.match_cnt, 2);
`endif

        // Randomised traffic with occasional reloads.
        begin
            bit ov = 1'b1;
            for (int n = 0; n < 700; n++) begin
                if ($urandom_range(0, 39) == 0) begin
                    int         l;
                    logic [7:0] v, mk;
                    l  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
                    v  = 8'($urandom);
                    mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
                    cyc(1'b1, v, l, mk, ov, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                end else begin
                    if ($urandom_range(0, 15) == 0) ov = ~ov;
                    cyc(1'b0, 8'h00, 0, 8'hFF, ov, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
                end
            end
        end

        idle(1'b1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Runtime-programmable serial bit-sequence detector with a Moore-style registered match output. Generalises the fixed 4-bit-pattern detector to any pattern length 1..PAT_W. Adds selectable overlap / non-overlap mode, a valid-qualified input stream and a saturating match counter. Sits on a serial input path and flags or counts occurrences of a configured pattern.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of pat_len; must hold PAT_W (>= clog2(PAT_W+1))
CNT_W, 8, width of saturating match counter

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state
pat_load  in  1  1-cycle strobe; latches pat_val/pat_len, clears history and counter
pat_val  in  PAT_W  pattern; bit [len-1] is first bit received, bit [0] is last
pat_len  in  LEN_W  pattern length; valid range 1..PAT_W
overlap  in  1  1 = overlapping matches allowed, 0 = history flushed after each match
in_valid  in  1  qualifies in_bit; bit consumed only when high
in_bit  in  1  serial data bit
match  out  1  high exactly one cycle after the bit that completes the pattern
match_cnt  out  CNT_W  number of matches since last load/reset, saturating
armed  out  1  high when a valid pattern is loaded (state != IDLE)

Behaviour:
- Reset (async): state=IDLE, match=0, match_cnt=0, armed=0; pattern, length, history and fill registers = 0.
- Registers: pat_r[PAT_W], len_r[LEN_W], hist[PAT_W] (hist[0] newest), fill (0..PAT_W, saturates at PAT_W).
- States: IDLE (no valid pattern), ARMED (searching), MATCH (Moore output state; match=1 only here).
- pat_load: from any state, next cycle pat_r/len_r latched, hist=0, fill=0, match_cnt=0. If pat_len in 1..PAT_W -> ARMED, else -> IDLE (armed=0, no detection).
- pat_load and in_valid same cycle: load wins, bit discarded.
- IDLE: in_valid ignored; leaves only via a valid pat_load.
- ARMED/MATCH, in_valid=1: hist <= {hist[PAT_W-2:0], in_bit}; fill <= fill+1 (sat). Hit when (fill+1) >= len_r AND new hist[len_r-1:0] == pat_r[len_r-1:0] (bits above len_r ignored). Hit -> MATCH, else -> ARMED.
- On hit with overlap=0: hist and fill cleared instead of shifted, so the next match needs len_r fresh bits. overlap=1: shift retained.
- MATCH with in_valid=0 -> ARMED (match never lasts >1 cycle without a new hit); MATCH with in_valid=1 evaluated as ARMED, back-to-back hits hold match high on consecutive cycles.
- match_cnt increments on each entry into MATCH, i.e. same edge match rises; holds at 2^CNT_W-1.
- Latency: in_bit sampled at edge N -> match high in cycle N+1.
- overlap sampled on each consumed bit; changing it mid-stream affects only future hits.
- Reset mid-operation: immediate return to reset values; pattern must be reloaded.

Optional Feature:
SEQ_DET_MASK_EN: when defined, adds input pat_mask[PAT_W], latched with pat_load. Bits with mask=0 are don't-care in the compare: (hist ^ pat_r) & mask_r & len-mask == 0. When undefined, port absent; all len_r bits compared.

Test Plan:
- PAT_W=8: load pat_val=8'b0000_1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt=2.
- Same load, overlap=0; stream 1,0,1,1,0,1,1 -> single pulse after bit 4; match_cnt=1.
- Load len=3 pat=3'b111, overlap=1, stream 1,1,1,1,1 with in_valid low every other cycle -> match after bits 3,4,5, each 1 cycle wide, none in gap cycles; match_cnt=3.
- CNT_W=2: 5 matches -> match_cnt 1,2,3,3,3.
- Load len=0, then len=9 -> armed=0, no match for any stream; then len=2 pat=2'b10 -> armed=1 next cycle; pat_load with in_valid=1 same cycle -> bit dropped.
- Assert reset after 2 of 4 pattern bits -> match=0, match_cnt=0, armed=0 immediately; with SEQ_DET_MASK_EN, pat=1011 mask=1101 matches stream 1,0,0,1 and 1,0,1,1.
